vector_floating_point_add_sequencer: RTL and testbench
======================================================

Name: vector_floating_point_add_sequencer

Overview:
Sequences one vfadd/vfsub/vfrsub instruction across a register group (LMUL) through the combinational vector_floating_point_add_unit, one VLEN-wide beat per cycle. It reads vs1/vs2 beats from the vector register file, drives the add unit, registers the result and writes vd back with a tail byte mask. It sits between the vector issue stage and the execution units and holds one instruction at a time.

Parameters:
VLEN, 64, vector register width in bits (power of 2, >= 64)
VL_WIDTH, 8, width of the requested vl field

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
req_valid  input  1  instruction request valid
req_ready  output  1  sequencer can accept (high only in IDLE)
req_execution_vector  input  execution_vector_t  decoded control (vfadd_64, vfsub_32, ...) forwarded to the add unit
req_sew_64  input  1  1 = SEW 64, 0 = SEW 32
req_lmul_log2  input  2  log2 of LMUL (0..3 → 1,2,4,8 registers)
req_vl  input  VL_WIDTH  requested element count
req_vs1_index, req_vs2_index, req_vd_index  input  5 each  base register indices
vrf_read_index_a, vrf_read_index_b  output  5 each  vs2 and vs1 beat read indices (combinational read)
vrf_read_data_a, vrf_read_data_b  input  VLEN each  read data, same cycle
fpau_execution_vector  output  execution_vector_t  to add unit
fpau_vs2, fpau_vs1  output  VLEN each  to add unit
fpau_vd  input  VLEN  result from add unit
vrf_write_enable  output  1  write strobe
vrf_write_index  output  5  destination register
vrf_write_data  output  VLEN  registered result
vrf_write_mask  output  VLEN/8  byte enables
done  output  1  one-cycle pulse, instruction complete

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE; vrf_write_enable, done, vrf_write_index, vrf_write_data, vrf_write_mask, beat counter and latched request = 0; req_ready = 1 on the first cycle after reset. A reset mid-instruction aborts it: no further writes, no done.
- Accept on req_valid && req_ready. Latch all req_* fields.
- VLMAX = (VLEN/SEW) << lmul_log2. Effective vl = min(req_vl, VLMAX), so oversized vl is clamped silently.
- Beats N = ceil(vl*SEW/VLEN).
- States:
  - IDLE: req_ready = 1. On accept with vl = 0, go to DRAIN with no pending write. Otherwise go to EXECUTE with beat = 0.
  - EXECUTE: read indices are (vs2+beat) mod 32 and (vs1+beat) mod 32. fpau_* are driven from read data and the latched execution vector. Result, index (vd+beat) mod 32 and mask are registered at the clock edge. beat increments; after beat N-1, go to DRAIN.
  - DRAIN: writes the last registered beat, then returns to IDLE.
- Pipeline: a beat computed in cycle k is written in cycle k+1. Writes therefore overlap with the next compute. Accept in cycle 0 → computes in cycles 1..N, writes in cycles 2..N+1.
- done pulses in the same cycle as the final write (cycle N+1), or in cycle 1 when vl = 0 (write enable stays 0). req_ready is high again in cycle N+2.
- Mask: all ones except on the last beat. There, only bytes of elements with index < vl are enabled. Tail bytes are 0 (tail-undisturbed).
- fpau_* outputs are 0 outside EXECUTE.
- req_valid while busy is ignored and the request must be held. No input changes are accepted mid-instruction.

Optional Feature:
VFADD_SEQUENCER_BUSY_COUNTER_EN:
- Defined: adds output busy_cycles [31:0]. It is reset to 0 and increments on every cycle the state is not IDLE, wrapping at 2^32.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- SEW 32, lmul_log2 = 2, vl = 5, vs1 = 8, vs2 = 12, vd = 16, accept at cycle 0 → 3 writes in cycles 2/3/4 to v16/v17/v18; masks FF, FF, 0F; done in cycle 4; req_ready again in cycle 5; data equals add-unit output for each beat.
- SEW 64, vfsub_64, lmul_log2 = 3, vl = 8, vd = 28 → 8 writes to v28..v31 then v0..v3 (index wrap), all masks FF, done in cycle 9.
- vl = 0 → no write enable, done in cycle 1, IDLE in cycle 2.
- SEW 32, lmul_log2 = 0, vl = 20 → clamped to 2; 1 write, mask FF, done in cycle 2.
- Reset driven low in cycle 3 of the first scenario → no writes after reset, no done, req_ready = 1 in the cycle after reset is released; a new request is then accepted and executes correctly.
- Two back-to-back requests with req_valid held continuously → second accepted exactly in the cycle after the first done; with VFADD_SEQUENCER_BUSY_COUNTER_EN, busy_cycles equals the sum of the two busy periods (N+1 each).

Source files
------------

// File: rtl/vector_floating_point_add_sequencer.sv
// rtl/vector_floating_point_add_sequencer.sv - walks one vfadd/vfsub/vfrsub across an LMUL register group
// Optional feature macro: VFADD_SEQUENCER_BUSY_COUNTER_EN (adds busy_cycles output).
package vector_floating_point_add_pkg;
  typedef struct packed {
    logic vfadd_64;
    logic vfsub_64;
    logic vfrsub_64;
    logic vfadd_32;
    logic vfsub_32;
    logic vfrsub_32;
  } execution_vector_t;
endpackage

module vector_floating_point_add_sequencer
  import vector_floating_point_add_pkg::*;
#(
  parameter int VLEN     = 64,
  parameter int VL_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  execution_vector_t     req_execution_vector,
  input  logic                  req_sew_64,
  input  logic [1:0]            req_lmul_log2,
  input  logic [VL_WIDTH-1:0]   req_vl,
  input  logic [4:0]            req_vs1_index,
  input  logic [4:0]            req_vs2_index,
  input  logic [4:0]            req_vd_index,
  output logic [4:0]            vrf_read_index_a,
  output logic [4:0]            vrf_read_index_b,
  input  logic [VLEN-1:0]       vrf_read_data_a,
  input  logic [VLEN-1:0]       vrf_read_data_b,
  output execution_vector_t     fpau_execution_vector,
  output logic [VLEN-1:0]       fpau_vs2,
  output logic [VLEN-1:0]       fpau_vs1,
  input  logic [VLEN-1:0]       fpau_vd,
  output logic                  vrf_write_enable,
  output logic [4:0]            vrf_write_index,
  output logic [VLEN-1:0]       vrf_write_data,
  output logic [VLEN/8-1:0]     vrf_write_mask,
  output logic                  done
`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
  , output logic [31:0]         busy_cycles
`endif
);
  localparam int BYTES     = VLEN / 8;
  localparam int BYTE_LOG2 = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, EXECUTE, DRAIN} state_t;

  state_t             state;
  execution_vector_t  ev_q;
  logic [4:0]         vs1_q, vs2_q, vd_q;
  logic [3:0]         beats_q, beat;
  logic [BYTES-1:0]   last_mask_q;

  logic [31:0]        vlmax, eff_vl, total_bytes, beats_calc, tail;
  logic [BYTES-1:0]   last_mask_calc;
  logic               accept, last_beat, executing;

  // Clamp vl to VLMAX and derive beat count and last-beat byte mask at accept time.
  always_comb begin
    vlmax          = (req_sew_64 ? 32'(VLEN / 64) : 32'(VLEN / 32)) << req_lmul_log2;
    eff_vl         = (32'(req_vl) < vlmax) ? 32'(req_vl) : vlmax;
    total_bytes    = req_sew_64 ? (eff_vl << 3) : (eff_vl << 2);
    beats_calc     = (total_bytes + 32'(BYTES - 1)) >> BYTE_LOG2;
    tail           = total_bytes & 32'(BYTES - 1);
    last_mask_calc = '0;
    for (int i = 0; i < BYTES; i++) begin
      last_mask_calc[i] = (tail == 32'd0) || (32'(i) < tail);
    end
  end

  assign req_ready             = (state == IDLE);
  assign accept                = req_valid && req_ready;
  assign executing             = (state == EXECUTE);
  assign last_beat             = (beat == beats_q - 4'd1);
  assign vrf_read_index_a      = vs2_q + 5'(beat);
  assign vrf_read_index_b      = vs1_q + 5'(beat);
  assign fpau_execution_vector = executing ? ev_q : '0;
  assign fpau_vs2              = executing ? vrf_read_data_a : '0;
  assign fpau_vs1              = executing ? vrf_read_data_b : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= IDLE;
      ev_q             <= '0;
      vs1_q            <= '0;
      vs2_q            <= '0;
      vd_q             <= '0;
      beats_q          <= '0;
      beat             <= '0;
      last_mask_q      <= '0;
      vrf_write_enable <= 1'b0;
      vrf_write_index  <= '0;
      vrf_write_data   <= '0;
      vrf_write_mask   <= '0;
      done             <= 1'b0;
    end else begin
      vrf_write_enable <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ev_q        <= req_execution_vector;
            vs1_q       <= req_vs1_index;
            vs2_q       <= req_vs2_index;
            vd_q        <= req_vd_index;
            beats_q     <= beats_calc[3:0];
            last_mask_q <= last_mask_calc;
            beat        <= '0;
            if (eff_vl == 32'd0) begin
              state <= DRAIN;
              done  <= 1'b1;
            end else begin
              state <= EXECUTE;
            end
          end
        end
        EXECUTE: begin
          // The result registered here is written next cycle, overlapping the next compute.
          vrf_write_enable <= 1'b1;
          vrf_write_data   <= fpau_vd;
          vrf_write_index  <= vd_q + 5'(beat);
          vrf_write_mask   <= last_beat ? last_mask_q : '1;
          beat             <= beat + 4'd1;
          if (last_beat) begin
            state <= DRAIN;
            done  <= 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_cycles <= '0;
    end else if (state != IDLE) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_floating_point_add_sequencer.sv
// tb/tb_vector_floating_point_add_sequencer.sv - self-checking bench for vector_floating_point_add_sequencer
// Honours VFADD_SEQUENCER_BUSY_COUNTER_EN when defined.
module tb_vector_floating_point_add_sequencer;
  import vector_floating_point_add_pkg::*;

  localparam int VLEN     = 64;
  localparam int VL_WIDTH = 8;
  localparam int BYTES    = VLEN / 8;

  localparam logic [5:0] VFADD_64  = 6'b100000;
  localparam logic [5:0] VFSUB_64  = 6'b010000;
  localparam logic [5:0] VFADD_32  = 6'b000100;
  localparam logic [5:0] VFRSUB_32 = 6'b000001;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  execution_vector_t   req_execution_vector;
  logic                req_sew_64;
  logic [1:0]          req_lmul_log2;
  logic [VL_WIDTH-1:0] req_vl;
  logic [4:0]          req_vs1_index, req_vs2_index, req_vd_index;
  logic [4:0]          vrf_read_index_a, vrf_read_index_b;
  logic [VLEN-1:0]     vrf_read_data_a, vrf_read_data_b;
  execution_vector_t   fpau_execution_vector;
  logic [VLEN-1:0]     fpau_vs2, fpau_vs1, fpau_vd;
  logic                vrf_write_enable;
  logic [4:0]          vrf_write_index;
  logic [VLEN-1:0]     vrf_write_data;
  logic [BYTES-1:0]    vrf_write_mask;
  logic                done;
`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
  logic [31:0]         busy_cycles;
`endif

  vector_floating_point_add_sequencer #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_execution_vector(req_execution_vector), .req_sew_64(req_sew_64),
    .req_lmul_log2(req_lmul_log2), .req_vl(req_vl),
    .req_vs1_index(req_vs1_index), .req_vs2_index(req_vs2_index), .req_vd_index(req_vd_index),
    .vrf_read_index_a(vrf_read_index_a), .vrf_read_index_b(vrf_read_index_b),
    .vrf_read_data_a(vrf_read_data_a), .vrf_read_data_b(vrf_read_data_b),
    .fpau_execution_vector(fpau_execution_vector), .fpau_vs2(fpau_vs2), .fpau_vs1(fpau_vs1),
    .fpau_vd(fpau_vd),
    .vrf_write_enable(vrf_write_enable), .vrf_write_index(vrf_write_index),
    .vrf_write_data(vrf_write_data), .vrf_write_mask(vrf_write_mask),
    .done(done)
`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clock = ~clock;

  logic [VLEN-1:0] vrf [32];
  assign vrf_read_data_a = vrf[vrf_read_index_a];
  assign vrf_read_data_b = vrf[vrf_read_index_b];

  // Stand-in add unit: asymmetric in its operands so swapped reads are visible.
  function automatic logic [VLEN-1:0] addunit(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                              input logic [5:0] ev);
    return (a + (a << 1)) ^ {b[VLEN-5:0], b[VLEN-1:VLEN-4]} ^ {{(VLEN-6){1'b0}}, ev};
  endfunction
  assign fpau_vd = addunit(fpau_vs2, fpau_vs1, fpau_execution_vector);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: element-by-element byte enables over the register group.
  int               exp_n;
  logic [BYTES-1:0] exp_mask [8];

  task automatic model(input bit sew64, input int lmul, input int vl);
    int sewb, vlmax, evl, byte_pos;
    sewb  = sew64 ? 8 : 4;
    vlmax = (VLEN / (sewb * 8)) * (1 << lmul);
    evl   = (vl < vlmax) ? vl : vlmax;
    exp_n = (evl * sewb + BYTES - 1) / BYTES;
    for (int b = 0; b < 8; b++) exp_mask[b] = '0;
    for (int e = 0; e < evl; e++) begin
      for (int k = 0; k < sewb; k++) begin
        byte_pos = e * sewb + k;
        exp_mask[byte_pos / BYTES][byte_pos % BYTES] = 1'b1;
      end
    end
  endtask

  int               wr_cyc [$];
  logic [4:0]       wr_idx [$];
  logic [VLEN-1:0]  wr_data [$];
  logic [BYTES-1:0] wr_mask [$];

  task automatic drive_req(input bit sew64, input int lmul, input int vl, input int vs1,
                           input int vs2, input int vd, input logic [5:0] ev);
    req_sew_64           = sew64;
    req_lmul_log2        = 2'(lmul);
    req_vl               = VL_WIDTH'(vl);
    req_vs1_index        = 5'(vs1);
    req_vs2_index        = 5'(vs2);
    req_vd_index         = 5'(vd);
    req_execution_vector = execution_vector_t'(ev);
  endtask

  task automatic run_req(input string tag, input bit sew64, input int lmul, input int vl,
                         input int vs1, input int vs2, input int vd, input logic [5:0] ev);
    int bound, done_cyc, done_cnt, ready_cyc;
    bound = 0;
    while (!req_ready && bound < 50) begin
      @(posedge clock); #1;
      bound++;
    end
    if (!req_ready) begin
      check({tag, " ready_timeout"}, 64'(req_ready), 64'd1);
      return;
    end
    drive_req(sew64, lmul, vl, vs1, vs2, vd, ev);
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wr_cyc.delete(); wr_idx.delete(); wr_data.delete(); wr_mask.delete();
    done_cyc = -1; done_cnt = 0; ready_cyc = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (vrf_write_enable) begin
        wr_cyc.push_back(cyc); wr_idx.push_back(vrf_write_index);
        wr_data.push_back(vrf_write_data); wr_mask.push_back(vrf_write_mask);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (req_ready) begin
        ready_cyc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    model(sew64, lmul, vl);
    check({tag, " write_count"}, 64'(wr_idx.size()), 64'(exp_n));
    for (int i = 0; i < wr_idx.size() && i < exp_n; i++) begin
      check($sformatf("%s beat%0d index", tag, i), 64'(wr_idx[i]), 64'((vd + i) % 32));
      check($sformatf("%s beat%0d mask", tag, i), 64'(wr_mask[i]), 64'(exp_mask[i]));
      check($sformatf("%s beat%0d data", tag, i), wr_data[i],
            addunit(vrf[(vs2 + i) % 32], vrf[(vs1 + i) % 32], ev));
      check($sformatf("%s beat%0d cycle", tag, i), 64'(wr_cyc[i]), 64'(i + 2));
    end
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_n + 1));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " ready_cycle"}, 64'(ready_cyc), 64'(exp_n + 2));
  endtask

  typedef struct {
    bit              sew64;
    int              lmul;
    int              vl;
    int              vs1, vs2, vd;
    logic [5:0]      ev;
    int              exp_writes;
    logic [BYTES-1:0] exp_last_mask;
    int              exp_last_idx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cnt_we, cnt_done, c0;
    for (int i = 0; i < 32; i++) vrf[i] = {$urandom, $urandom};
    reset_n = 1'b0; req_valid = 1'b0;
    drive_req(1'b0, 0, 0, 0, 0, 0, 6'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset we", 64'(vrf_write_enable), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset index", 64'(vrf_write_index), 64'd0);
    check("reset data", vrf_write_data, 64'd0);
    check("reset mask", 64'(vrf_write_mask), 64'd0);
    check("reset fpau_vs2", fpau_vs2, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready after reset", 64'(req_ready), 64'd1);

    tbl[0] = '{1'b0, 2, 5,   8, 12, 16, VFADD_32,  3, 8'h0F, 18};
    tbl[1] = '{1'b1, 3, 8,   0,  4, 28, VFSUB_64,  8, 8'hFF, 3};
    tbl[2] = '{1'b0, 1, 0,   1,  2,  3, VFADD_32,  0, 8'h00, 0};
    tbl[3] = '{1'b0, 0, 20,  5,  6,  7, VFADD_32,  1, 8'hFF, 7};
    tbl[4] = '{1'b0, 3, 3,  30, 29, 31, VFRSUB_32, 2, 8'h0F, 0};
    tbl[5] = '{1'b1, 0, 255, 9, 10, 11, VFADD_64,  1, 8'hFF, 11};
    for (int t = 0; t < 6; t++) begin
      run_req($sformatf("tbl%0d", t), tbl[t].sew64, tbl[t].lmul, tbl[t].vl,
              tbl[t].vs1, tbl[t].vs2, tbl[t].vd, tbl[t].ev);
      check($sformatf("tbl%0d n", t), 64'(wr_idx.size()), 64'(tbl[t].exp_writes));
      if (tbl[t].exp_writes > 0 && wr_idx.size() > 0) begin
        check($sformatf("tbl%0d last_mask", t), 64'(wr_mask[wr_idx.size()-1]), 64'(tbl[t].exp_last_mask));
        check($sformatf("tbl%0d last_idx", t), 64'(wr_idx[wr_idx.size()-1]), 64'(tbl[t].exp_last_idx));
      end
    end

    // Reset mid-instruction in cycle 3 of the first scenario.
    drive_req(1'b0, 2, 5, 8, 12, 16, VFADD_32);
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    cnt_we = 0; cnt_done = 0;
    for (int cyc = 4; cyc <= 8; cyc++) begin
      if (vrf_write_enable) cnt_we++;
      if (done) cnt_done++;
      if (cyc == 5) check("abort ready", 64'(req_ready), 64'd1);
      @(posedge clock); #1;
    end
    check("abort writes", 64'(cnt_we), 64'd0);
    check("abort done", 64'(cnt_done), 64'd0);
    run_req("post_reset", 1'b0, 2, 5, 8, 12, 16, VFADD_32);

    // Back-to-back with req_valid held: A (2 beats) then B (1 beat).
`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
    c0 = int'(busy_cycles);
`else
    c0 = 0;
`endif
    drive_req(1'b1, 1, 2, 3, 4, 5, VFADD_64);
    req_valid = 1'b1;
    cnt_we = 0; cnt_done = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 1) drive_req(1'b0, 0, 1, 20, 21, 22, VFRSUB_32);
      if (cyc == 5) req_valid = 1'b0;
      if (vrf_write_enable) begin
        cnt_we++;
        if (cyc == 6) begin
          check("b2b B index", 64'(vrf_write_index), 64'd22);
          check("b2b B mask", 64'(vrf_write_mask), 64'h0F);
          check("b2b B data", vrf_write_data, addunit(vrf[21], vrf[20], VFRSUB_32));
        end
      end
      if (done) begin
        cnt_done++;
        check($sformatf("b2b done cyc%0d", cyc), 64'(cyc == 3 || cyc == 6), 64'd1);
      end
      if (cyc == 4) check("b2b accept B ready", 64'(req_ready), 64'd1);
      if (cyc == 5) check("b2b B busy", 64'(req_ready), 64'd0);
    end
    check("b2b writes", 64'(cnt_we), 64'd3);
    check("b2b dones", 64'(cnt_done), 64'd2);
`ifdef VFADD_SEQUENCER_BUSY_COUNTER_EN
    check("busy_cycles", 64'(busy_cycles), 64'(c0 + 5));
`else
    check("b2b idle", 64'(c0 + int'(req_ready)), 64'd1);
`endif

    for (int r = 0; r < 12; r++) begin
      bit s64;
      logic [5:0] ev;
      s64 = 1'($urandom_range(0, 1));
      ev  = s64 ? (VFADD_64 >> $urandom_range(0, 2)) : (VFADD_32 >> $urandom_range(0, 2));
      run_req($sformatf("rand%0d", r), s64, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
